im_loader: RTL and testbench

Write-side companion to the instruction memory read port. It receives a byte stream, typically from the UART receiver, and assembles 17-bit instructions from it. It writes them sequentially into instruction memory starting at address 0, and holds the CPU in reset until the image is complete. It sits between the byte source and the instruction memory write port, and drives the CPU hold.

---
 rtl/im_loader_pkg.sv | 20 ++
 rtl/im_loader_if.sv | 11 +
 rtl/im_word_asm.sv | 68 ++++++
 rtl/im_loader.sv | 137 +++++++++++++
 tb/tb_im_loader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// Shared widths and FSM state encoding for the instruction-memory loader.
package im_pkg;

  localparam int unsigned IM_ADDR_W = 11;
  localparam int unsigned IM_DATA_W = 17;
  localparam int unsigned IM_DEPTH  = 2048;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CNT_LO = 4'd1,
    CNT_HI = 4'd2,
    B0     = 4'd3,
    B1     = 4'd4,
    B2     = 4'd5,
    WRITE  = 4'd6,
    DONE   = 4'd7,
    ERR    = 4'd8
  } ld_state_t;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream valid/ready handshake between a byte source and the loader.
interface im_loader_if;

  logic       byte_vld;
  logic [7:0] byte_in;
  logic       byte_rdy;

  modport master (output byte_vld, output byte_in, input byte_rdy);
  modport slave  (input byte_vld, input byte_in, output byte_rdy);

endinterface

// File: rtl/im_word_asm.sv
// Collects three stream bytes into one instruction word; word_ready pulses for
// the cycle after the third byte, while the word register holds the result.
module im_word_asm
  import im_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 take_i,
  input  logic [7:0]           byte_i,
  output logic [IM_DATA_W-1:0] word_o,
  output logic                 word_ready_o
);

  logic [7:0]           b0_q, b0_d;
  logic [7:0]           b1_q, b1_d;
  logic [1:0]           idx_q, idx_d;
  logic [IM_DATA_W-1:0] word_q, word_d;
  logic                 ready_q, ready_d;

  always_comb begin
    b0_d    = b0_q;
    b1_d    = b1_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ready_d = 1'b0;
    if (clr_i) begin
      idx_d = 2'd0;
    end else if (take_i) begin
      case (idx_q)
        2'd0: begin
          b0_d  = byte_i;
          idx_d = 2'd1;
        end
        2'd1: begin
          b1_d  = byte_i;
          idx_d = 2'd2;
        end
        default: begin
          // Only bit 0 of the third byte carries instruction data.
          word_d  = {byte_i[0], b1_q, b0_q};
          ready_d = 1'b1;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q    <= '0;
      b1_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = ready_q;

endmodule

// File: rtl/im_loader.sv
// Loads a counted byte stream into instruction memory and holds the CPU in
// reset until the whole image has been written.
module im_loader
  import im_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start_i,
  im_loader_if.slave           bus,
  output logic                 im_we_o,
  output logic [IM_ADDR_W-1:0] im_waddr_o,
  output logic [IM_DATA_W-1:0] im_wdata_o,
  output logic                 cpu_hold_o,
  output logic                 load_done_o,
  output logic                 load_err_o
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned CNT_W = IM_ADDR_W + 1;

  ld_state_t            state_q, state_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [IM_ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic                 byte_rdy_q, byte_rdy_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 load_done_q, load_done_d;
  logic                 load_err_q, load_err_d;

  logic                 accept_c;
  logic                 asm_clr_c;
  logic                 asm_take_c;
  logic [CNT_W-1:0]     n_hdr_c;
  logic [IM_DATA_W-1:0] asm_word;
  logic                 asm_ready;

  assign accept_c   = bus.byte_vld && byte_rdy_q;
  assign n_hdr_c    = {bus.byte_in[3:0], n_q[7:0]};
  assign asm_take_c = accept_c && (state_q inside {B0, B1, B2});

  // Next state, counters and registered output values.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    to_d      = to_q;
    asm_clr_c = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start_i) begin
          state_d   = CNT_LO;
          addr_d    = '0;
          to_d      = '0;
          asm_clr_c = 1'b1;
        end
      end
      CNT_LO: if (accept_c) begin
        n_d     = CNT_W'(bus.byte_in);
        state_d = CNT_HI;
      end
      CNT_HI: if (accept_c) begin
        n_d = n_hdr_c;
        if (n_hdr_c == '0 || n_hdr_c > CNT_W'(IM_DEPTH)) state_d = ERR;
        else                                             state_d = B0;
      end
      B0: if (accept_c) state_d = B1;
      B1: if (accept_c) state_d = B2;
      B2: if (accept_c) state_d = WRITE;
      WRITE: begin
        addr_d = addr_q + IM_ADDR_W'(1);
        // Compare against the count so a full-depth image never wraps.
        if (CNT_W'(addr_q) + CNT_W'(1) == n_q) state_d = DONE;
        else                                   state_d = B0;
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte idle timer; an accepted byte always wins over expiry.
    if (state_q inside {CNT_LO, CNT_HI, B0, B1, B2}) begin
      if (accept_c) begin
        to_d = '0;
      end else if (state_q != CNT_LO) begin
        if (to_q == TO_W'(TIMEOUT_CYC - 1)) state_d = ERR;
        else                                to_d    = to_q + TO_W'(1);
      end
    end

    byte_rdy_d  = state_d inside {CNT_LO, CNT_HI, B0, B1, B2};
    cpu_hold_d  = (state_d != DONE);
    load_done_d = (state_d == DONE);
    load_err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      addr_q      <= '0;
      to_q        <= '0;
      byte_rdy_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      to_q        <= to_d;
      byte_rdy_q  <= byte_rdy_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  im_word_asm u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (asm_clr_c),
    .take_i       (asm_take_c),
    .byte_i       (bus.byte_in),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  assign bus.byte_rdy = byte_rdy_q;
  assign im_we_o      = asm_ready;
  assign im_waddr_o   = addr_q;
  assign im_wdata_o   = asm_word;
  assign cpu_hold_o   = cpu_hold_q;
  assign load_done_o  = load_done_q;
  assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: header/word stream loads, bad counts, timeout,
// backpressure and mid-load reset, with a write monitor on the memory port.
module tb_im_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        im_we;
  logic [10:0] im_waddr;
  logic [16:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_assert = 0;
  int n_fail   = 0;
  int bad      = 0;
  int we_before;

  logic [10:0] wr_addr[$];
  logic [16:0] wr_data[$];

  im_loader_if bus ();

  im_loader #(.TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start_i (load_start),
    .bus          (bus),
    .im_we_o      (im_we),
    .im_waddr_o   (im_waddr),
    .im_wdata_o   (im_wdata),
    .cpu_hold_o   (cpu_hold),
    .load_done_o  (load_done),
    .load_err_o   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor; every write must also coincide with byte_rdy low.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_waddr);
      wr_data.push_back(im_wdata);
      chk("rdy_low_in_write", 32'(bus.byte_rdy), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.byte_vld = 1'b1;
    bus.byte_in  = b;
    while (bus.byte_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("byte_rdy_wait", 32'(bus.byte_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.byte_vld = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    load_start   = 1'b0;
    bus.byte_vld = 1'b0;
    bus.byte_in  = 8'h00;

    // Reset values
    #12;
    chk("rst_byte_rdy", 32'(bus.byte_rdy), 32'd0);
    chk("rst_im_we",    32'(im_we),        32'd0);
    chk("rst_waddr",    32'(im_waddr),     32'd0);
    chk("rst_wdata",    32'(im_wdata),     32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold),     32'd1);
    chk("rst_done",     32'(load_done),    32'd0);
    chk("rst_err",      32'(load_err),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bytes offered in IDLE are dropped and change nothing
    @(negedge clk);
    bus.byte_vld = 1'b1;
    bus.byte_in  = 8'h02;
    repeat (3) @(negedge clk);
    chk("idle_rdy",  32'(bus.byte_rdy), 32'd0);
    chk("idle_hold", 32'(cpu_hold),     32'd1);
    chk("idle_done", 32'(load_done),    32'd0);
    chk("idle_err",  32'(load_err),     32'd0);
    bus.byte_vld = 1'b0;

    // Basic two-word load, with an ignored load_start mid-load
    clear_log();
    start_pulse();
    chk("start_rdy",  32'(bus.byte_rdy), 32'd1);
    chk("start_hold", 32'(cpu_hold),     32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    start_pulse();
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h01);
    chk("w0_we_latency", 32'(im_we),    32'd1);
    chk("w0_waddr",      32'(im_waddr), 32'h0);
    chk("w0_wdata",      32'(im_wdata), 32'h11234);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    chk("w1_we_latency", 32'(im_we),     32'd1);
    chk("w1_done_early", 32'(load_done), 32'd0);
    @(posedge clk);
    #1;
    chk("basic_done",     32'(load_done), 32'd1);
    chk("basic_hold",     32'(cpu_hold),  32'd0);
    chk("basic_err",      32'(load_err),  32'd0);
    chk("basic_we_after", 32'(im_we),     32'd0);
    chk("basic_rdy_done", 32'(bus.byte_rdy), 32'd0);
    repeat (2) @(negedge clk);
    chk("basic_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("basic_a0", 32'(wr_addr[0]), 32'h0);
      chk("basic_d0", 32'(wr_data[0]), 32'h11234);
      chk("basic_a1", 32'(wr_addr[1]), 32'h1);
      chk("basic_d1", 32'(wr_data[1]), 32'h0FFFF);
    end

    // Single word; header high nibble and b2[7:1] ignored
    clear_log();
    start_pulse();
    chk("restart_clears_done", 32'(load_done), 32'd0);
    chk("restart_hold",        32'(cpu_hold),  32'd1);
    send_byte(8'h01);
    send_byte(8'hF0);
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'hFE);
    repeat (3) @(negedge clk);
    chk("one_done",  32'(load_done),       32'd1);
    chk("one_count", 32'(wr_addr.size()),  32'd1);
    if (wr_addr.size() == 1) chk("one_d0", 32'(wr_data[0]), 32'h0ABCD);

    // Full-depth load, word i = i
    clear_log();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h08);
    for (int i = 0; i < 2048; i++) begin
      send_byte(8'(i));
      send_byte(8'(i >> 8));
      send_byte(8'hFE);
    end
    repeat (3) @(negedge clk);
    chk("full_done",  32'(load_done),      32'd1);
    chk("full_hold",  32'(cpu_hold),       32'd0);
    chk("full_count", 32'(wr_addr.size()), 32'd2048);
    if (wr_addr.size() == 2048) begin
      bad = 0;
      for (int i = 0; i < 2048; i++)
        if (wr_addr[i] !== 11'(i) || wr_data[i] !== 17'(i)) bad++;
      chk("full_contents", 32'(bad),            32'd0);
      chk("full_last_a",   32'(wr_addr[2047]),  32'h7FF);
      chk("full_last_d",   32'(wr_data[2047]),  32'h007FF);
    end

    // Bad count N=0
    clear_log();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    chk("n0_err",  32'(load_err),     32'd1);
    chk("n0_hold", 32'(cpu_hold),     32'd1);
    chk("n0_done", 32'(load_done),    32'd0);
    chk("n0_rdy",  32'(bus.byte_rdy), 32'd0);

    // Bad count N=2049
    start_pulse();
    chk("restart_clears_err", 32'(load_err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h08);
    @(negedge clk);
    chk("n2049_err",  32'(load_err),      32'd1);
    chk("n2049_hold", 32'(cpu_hold),      32'd1);
    chk("bad_no_we",  32'(wr_addr.size()), 32'd0);

    // Start with a simultaneous byte in ERR: start taken, byte dropped
    @(negedge clk);
    load_start   = 1'b1;
    bus.byte_vld = 1'b1;
    bus.byte_in  = 8'h05;
    @(negedge clk);
    load_start   = 1'b0;
    bus.byte_vld = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h01);
    repeat (3) @(negedge clk);
    chk("recover_done",  32'(load_done),      32'd1);
    chk("recover_err",   32'(load_err),       32'd0);
    chk("recover_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) chk("recover_d0", 32'(wr_data[0]), 32'h15678);

    // Timeout: N=1, b0 and b1 sent, then stall
    clear_log();
    start_pulse();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (15) @(posedge clk);
    #1;
    chk("to_not_yet", 32'(load_err),     32'd0);
    chk("to_rdy",     32'(bus.byte_rdy), 32'd1);
    @(posedge clk);
    #1;
    chk("to_err",  32'(load_err), 32'd1);
    chk("to_hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    chk("to_no_we", 32'(wr_addr.size()), 32'd0);

    // Mid-load reset between b1 and b2 of word 3
    clear_log();
    start_pulse();
    send_byte(8'h05);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h10 + 8'(i));
      send_byte(8'h20);
      send_byte(8'h00);
    end
    send_byte(8'h13);
    send_byte(8'h20);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rdy",   32'(bus.byte_rdy), 32'd0);
    chk("mr_we",    32'(im_we),        32'd0);
    chk("mr_waddr", 32'(im_waddr),     32'd0);
    chk("mr_wdata", 32'(im_wdata),     32'd0);
    chk("mr_hold",  32'(cpu_hold),     32'd1);
    chk("mr_done",  32'(load_done),    32'd0);
    chk("mr_err",   32'(load_err),     32'd0);
    we_before = wr_addr.size();
    chk("mr_writes_before", 32'(we_before), 32'd3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.byte_vld = 1'b1;
    bus.byte_in  = 8'h01;
    repeat (4) @(negedge clk);
    bus.byte_vld = 1'b0;
    chk("mr_no_we_after", 32'(wr_addr.size()), 32'd3);
    chk("mr_hold_after",  32'(cpu_hold),       32'd1);
    chk("mr_rdy_after",   32'(bus.byte_rdy),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
